// File: rtl/sensor_quorum_validator.sv
// Quorum/persistence event validator with lone-channel fault flags.
// Optional timestamping is enabled by defining SQV_TIMESTAMP_EN.
module sensor_quorum_validator #(
    parameter int N_CH    = 4,
    parameter int QUORUM  = 4,
    parameter int PERSIST = 8,
    parameter int TS_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   sense,
    input  logic              fault_clr,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [TS_W-1:0]   evt_ts,
    output logic [N_CH-1:0]   evt_mask,
    output logic              event_active,
    output logic              evt_overrun,
    output logic [N_CH-1:0]   fault_mask,
    output logic              fault_any,
    output logic [TS_W-1:0]   ts_now
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int          CW   = $clog2(N_CH + 1);
    localparam logic [7:0]  PMAX = 8'(PERSIST);

    state_t            state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [7:0]        pc_inc;
    logic [N_CH-1:0]   sense_q, sense_d;
    logic [N_CH-1:0]   cap_mask_q, cap_mask_d;
    logic [CW-1:0]     cnt;
    logic              q;
    logic              emit;
    logic [N_CH-1:0]   emit_mask;
    logic              load;
    logic              evt_valid_q, evt_valid_d;
    logic [N_CH-1:0]   evt_mask_q, evt_mask_d;
    logic              overrun_q, overrun_d;
    logic              active_q, active_d;
    logic [7:0]        lone_q [N_CH];
    logic [7:0]        lone_d [N_CH];
    logic [N_CH-1:0]   fault_set;
    logic [N_CH-1:0]   fault_q, fault_d;
    logic              fault_any_q, fault_any_d;

    assign sense_d = sense;
    assign pc_inc  = pc_q + 8'd1;

    // Count asserted channels in the registered sample.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt = cnt + CW'(sense_q[i]);
        end
    end

    assign q = (int'(cnt) >= QUORUM);

    // Next state, shared persistence counter and window mask.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cap_mask_d = cap_mask_q;
        emit       = 1'b0;
        emit_mask  = '0;
        unique case (state_q)
            IDLE: begin
                if (q) begin
                    pc_d       = 8'd1;
                    cap_mask_d = sense_q;
                    if (PMAX == 8'd1) begin
                        state_d   = ACTIVE;
                        emit      = 1'b1;
                        emit_mask = sense_q;
                    end else begin
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (q) begin
                    pc_d       = pc_inc;
                    cap_mask_d = cap_mask_q | sense_q;
                    if (pc_inc == PMAX) begin
                        state_d   = ACTIVE;
                        emit      = 1'b1;
                        emit_mask = cap_mask_q | sense_q;
                    end
                end else begin
                    state_d    = IDLE;
                    pc_d       = '0;
                    cap_mask_d = '0;
                end
            end
            ACTIVE: begin
                if (!q) begin
                    pc_d    = 8'd1;
                    state_d = (PMAX == 8'd1) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (q) begin
                    state_d = ACTIVE;
                end else begin
                    pc_d = pc_inc;
                    if (pc_inc == PMAX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Record slot: load when free or being drained, otherwise drop.
    always_comb begin
        load        = emit && (!evt_valid_q || evt_ready);
        evt_valid_d = evt_valid_q;
        evt_mask_d  = evt_mask_q;
        overrun_d   = overrun_q;
        if (load) begin
            evt_valid_d = 1'b1;
            evt_mask_d  = emit_mask;
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        if (fault_clr) begin
            overrun_d = 1'b0;
        end
        if (emit && !load) begin
            overrun_d = 1'b1;
        end
        active_d = (state_d == ACTIVE) || (state_d == RELEASE);
    end

    // Per-channel lone counters and sticky fault flags.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if ((state_q == IDLE) && !q && sense_q[i]) begin
                lone_d[i] = (lone_q[i] == PMAX) ? PMAX : lone_q[i] + 8'd1;
            end else begin
                lone_d[i] = '0;
            end
            fault_set[i] = (lone_d[i] == PMAX) && (lone_q[i] != PMAX);
        end
        fault_d     = fault_clr ? '0 : fault_q;
        fault_d     = fault_d | fault_set;
        fault_any_d = |fault_d;
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            sense_q     <= '0;
            cap_mask_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_mask_q  <= '0;
            overrun_q   <= 1'b0;
            active_q    <= 1'b0;
            fault_q     <= '0;
            fault_any_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                lone_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sense_q     <= sense_d;
            cap_mask_q  <= cap_mask_d;
            evt_valid_q <= evt_valid_d;
            evt_mask_q  <= evt_mask_d;
            overrun_q   <= overrun_d;
            active_q    <= active_d;
            fault_q     <= fault_d;
            fault_any_q <= fault_any_d;
            for (int i = 0; i < N_CH; i++) begin
                lone_q[i] <= lone_d[i];
            end
        end
    end

`ifdef SQV_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] cap_ts_q, cap_ts_d;
    logic [TS_W-1:0] evt_ts_q, evt_ts_d;
    logic            cap_take;
    logic [TS_W-1:0] emit_ts;

    assign cap_take = (state_q == IDLE) && q;

    // Free-running time base and onset capture.
    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        emit_ts  = cap_take ? ts_q : cap_ts_q;
        cap_ts_d = emit_ts;
        evt_ts_d = load ? emit_ts : evt_ts_q;
    end

    // Timestamp registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q     <= '0;
            cap_ts_q <= '0;
            evt_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            cap_ts_q <= cap_ts_d;
            evt_ts_q <= evt_ts_d;
        end
    end

    assign ts_now = ts_q;
    assign evt_ts = evt_ts_q;
`else
    assign ts_now = '0;
    assign evt_ts = '0;
`endif

    assign evt_valid    = evt_valid_q;
    assign evt_mask     = evt_mask_q;
    assign event_active = active_q;
    assign evt_overrun  = overrun_q;
    assign fault_mask   = fault_q;
    assign fault_any    = fault_any_q;

endmodule

// File: doc/sensor_quorum_validator.md
# sensor_quorum_validator

Parametrised successor to the fixed four-sensor agreement comparator in the smart-irrigation event path. It samples `N_CH` binary sensor indications and declares a trustworthy event only when at least `QUORUM` channels agree for `PERSIST` consecutive cycles. Each declared event is delivered as a timestamped record over a valid/ready handshake. Any channel that asserts alone for `PERSIST` cycles is flagged sticky as faulty.

## Interface
Parameters:
- `N_CH`, 4, number of sensor channels (2..16)
- `QUORUM`, 4, minimum asserted channels for an event (1..`N_CH`)
- `PERSIST`, 8, consecutive cycles required to qualify, release, or fault (1..255)
- `TS_W`, 32, timestamp width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `sense` in `N_CH`: raw sensor indications; bit i is channel i
- `fault_clr` in 1: one-cycle clear of `fault_mask`
- `evt_ready` in 1: consumer accepts the record
- `evt_valid` out 1: event record pending
- `evt_ts` out `TS_W`: timestamp at quorum onset
- `evt_mask` out `N_CH`: OR of registered `sense` over the qualifying window
- `event_active` out 1: high while in ACTIVE or RELEASE
- `evt_overrun` out 1: sticky; an event was dropped; cleared by `fault_clr`
- `fault_mask` out `N_CH`: sticky per-channel fault flags
- `fault_any` out 1: OR of `fault_mask`
- `ts_now` out `TS_W`: free-running timestamp counter

## Operation
- `sense` is registered once into `sense_q`. `cnt` = popcount(`sense_q`). `q` = (`cnt` >= `QUORUM`).
- `ts_now` increments every cycle and wraps modulo 2^`TS_W`.
- FSM states, with a shared counter `pc`:
  - IDLE: if `q`, load `pc`=1, capture `ts_now` and `sense_q`, go to QUALIFY. With `PERSIST`=1, go straight to ACTIVE and emit.
  - QUALIFY: if `q`, increment `pc` and OR `sense_q` into the mask. When `pc` reaches `PERSIST`, go to ACTIVE and emit the record. If not `q`, go to IDLE and discard the capture.
  - ACTIVE: if not `q`, load `pc`=1 and go to RELEASE.
  - RELEASE: if `q`, go back to ACTIVE with no new record. Otherwise increment `pc`; when it reaches `PERSIST`, go to IDLE.
- Emit rules:
  - If `evt_valid`=0, or `evt_valid`&`evt_ready` in the same cycle, load `evt_ts`/`evt_mask` and set `evt_valid`.
  - Otherwise keep the old record, drop the new one, and set `evt_overrun`.
- Handshake:
  - `evt_valid` stays high and `evt_ts`/`evt_mask` stay stable until `evt_valid`&`evt_ready`.
  - On that cycle `evt_valid` clears, unless a new emit occurs in the same cycle.
- Fault detection:
  - Each channel has a lone counter. It increments when state is IDLE, not `q`, and `sense_q[i]`=1. It is zeroed otherwise.
  - Reaching `PERSIST` sets `fault_mask[i]`; the counter saturates there.
  - If `fault_clr` and a set occur in the same cycle, the set wins.
- Reset mid-operation: the FSM returns to IDLE immediately, any pending record is lost, and all counters are zeroed.

## Timing
- Reset values: `evt_valid`=0, `evt_ts`=0, `evt_mask`=0, `event_active`=0, `evt_overrun`=0, `fault_mask`=0, `fault_any`=0, `ts_now`=0, `sense_q`=0. The FSM is in IDLE.
- Latency: with `sense` meeting quorum before edge 0, `sense_q` updates at edge 0, IDLE→QUALIFY at edge 1, and `evt_valid`=1 after edge `PERSIST`.
- `event_active` rises on the same edge as `evt_valid`.
- Release: `event_active` falls `PERSIST` edges after the first non-quorum `sense_q` evaluation.
- Fault: `fault_mask[i]` sets `PERSIST` edges after the first lone evaluation of channel i.
- `evt_ts` = `ts_now` value sampled at the IDLE→QUALIFY edge, before that edge's increment.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SQV_TIMESTAMP_EN` defined: `ts_now` counter is present and `evt_ts` carries the capture.
- `SQV_TIMESTAMP_EN` undefined: counter and capture logic are removed, and `evt_ts` and `ts_now` are tied to 0. All other behaviour is identical.

## Test plan
- Defaults; all four `sense` bits =1 for 20 cycles, `evt_ready`=1 → exactly one record; `evt_mask`=4'b1111; `evt_valid` high after edge 8; `event_active` falls 8 cycles after `sense` drops.
- Quorum held only 7 cycles, then broken → no `evt_valid`, FSM back to IDLE.
- Only `sense[1]`=1 for 10 cycles → `fault_mask`=4'b0010 after edge 8, `fault_any`=1, no event. Then `fault_clr` pulse → `fault_mask`=0, `evt_overrun`=0.
- `evt_ready`=0, two quorum events separated by full release → first record is held unchanged and `evt_overrun`=1. Then `evt_ready` pulse → `evt_valid`=0.
- Quorum drops for 3 cycles inside ACTIVE, then returns → `event_active` stays 1, no second record.
- `N_CH`=8, `QUORUM`=5, `PERSIST`=1; 5 bits high for one sampled cycle → record emitted one edge after the IDLE evaluation. Then assert `rst` asynchronously while `evt_valid`=1 → all outputs 0 immediately.
